ppu_requant_buffer: RTL and testbench
=====================================

Name: ppu_requant_buffer

Overview:
Parametrised post-processing unit. Takes one row of LANES signed accumulator partial sums per beat from the systolic array. Requantises each lane (scale, rounding shift, bias, optional ReLU, saturation) and stores the resulting OUT_W-bit row in an on-chip row buffer of DEPTH rows. Drains to the writeback path over a valid/ready stream, replacing the fixed 16-row latch array and fixed-format PPU.

Parameters:
LANES, 16, number of lanes per row
ACC_W, 24, signed partial-sum width per lane
SCALE_W, 8, unsigned scale width
BIAS_W, 8, signed bias width
SHIFT_W, 5, right-shift amount width
OUT_W, 8, signed output width per lane
DEPTH, 16, row-buffer depth in rows (power of 2, ≥2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input row valid
in_ready  out  1  input row accepted when in_valid&&in_ready
partial_sum  in  LANES*ACC_W  lane i at bits [i*ACC_W +: ACC_W], signed
scale  in  SCALE_W  unsigned multiplier, sampled with the row
bias  in  BIAS_W  signed bias, sampled with the row
shift  in  SHIFT_W  arithmetic right shift, sampled with the row
relu_en  in  1  clamp negatives to 0, sampled with the row
out_valid  out  1  buffer non-empty; out_data holds the head row
out_ready  in  1  pop head row when out_valid&&out_ready
out_data  out  LANES*OUT_W  head row, lane i at [i*OUT_W +: OUT_W]
count  out  $clog2(DEPTH+1)  rows stored in the buffer
full  out  1  count==DEPTH
sat_count  out  16  saturated-lane counter (see Optional Feature)
sat_clr  in  1  clears sat_count

Behaviour:
- Reset (async, rst=1): pipeline valids=0, buffer pointers=0, count=0, full=0, out_valid=0, out_data=0, sat_count=0. in_ready=1 after reset release. Reset mid-operation discards all in-flight and buffered rows.
- Pipeline is 3 stages. A row accepted at edge N is written to the buffer at edge N+3 and is visible on out_valid/out_data after edge N+3 if the buffer was empty.
  - S1: p = signed(acc) * unsigned(scale), full ACC_W+SCALE_W+1 bits, no truncation.
  - S2: r = (p + (shift>0 ? 2^(shift-1) : 0)) >>> shift, round half up. Then r = r + sign-extended bias. Width is sufficient; no internal overflow.
  - S3: if relu_en and r<0, r=0. Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. A lane is saturated iff its value was clamped by this step; the ReLU clamp does not count.
- scale/bias/shift/relu_en travel with their row; changing them between beats affects only later rows.
- Flow control: in_ready = (count + inflight) < DEPTH, where inflight = number of valid pipeline stages. The buffer never overflows and the pipeline never stalls. A row already in flight always completes.
- Buffer: circular with show-ahead. Write and read pointers wrap modulo DEPTH.
- Simultaneous write and pop: count unchanged. When count==1, the popped row leaves and the new row becomes the head on the next cycle.
- Pop while empty: ignored. out_data holds its last value when empty.
- full asserts on the edge count reaches DEPTH and deasserts on the first pop.

Optional Feature:
Macro PPU_SAT_STATS_EN.
- Defined: sat_count increments by the number of saturated lanes in each row written to the buffer. It sticks at 16'hFFFF. sat_clr=1 zeroes it that cycle; clear wins over a same-cycle increment.
- Not defined: sat_count is tied to 0, sat_clr is ignored, and no counter logic is present.

Test Plan:
- All lanes acc=24'h800000 (-8388608), scale=16, bias=1, shift=0, relu_en=0 → out_data all lanes 8'h80 after 3 cycles; with macro, sat_count=16.
- Same row with relu_en=1 → all lanes 8'h00; sat_count unchanged.
- Lane 0 acc=100, scale=3, shift=2, bias=5 → 8'h50 (80). Lane 1 acc=-6, scale=1, shift=2, bias=0 → 8'hFF (-1).
- out_ready=0, in_valid=1 continuously → exactly 16 rows accepted, in_ready=0, full=1, count=16. Then out_ready=1 → rows drain in input order, 16 pops, then out_valid=0.
- Steady stream with in_valid=1 and out_ready=1 → one row in and one out per cycle after 3-cycle fill; count stays at 1, in_ready stays 1.
- Assert rst with 5 rows buffered and 2 in flight → count=0, out_valid=0, sat_count=0 immediately; after release, the next accepted row is the first output.

Source files
------------

// File: rtl/ppu_requant_buffer.sv
// ppu_requant_buffer: 3-stage lane requantiser (scale, round-shift, bias, relu, saturate) feeding a show-ahead row buffer.
// Optional saturation statistics are enabled with `define PPU_SAT_STATS_EN.
module ppu_requant_buffer #(
  parameter int LANES   = 16,
  parameter int ACC_W   = 24,
  parameter int SCALE_W = 8,
  parameter int BIAS_W  = 8,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 8,
  parameter int DEPTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*ACC_W-1:0]         partial_sum,
  input  logic [SCALE_W-1:0]             scale,
  input  logic [BIAS_W-1:0]              bias,
  input  logic [SHIFT_W-1:0]             shift,
  input  logic                           relu_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic [15:0]                    sat_count,
  input  logic                           sat_clr
);
  localparam int PW = ACC_W + SCALE_W + 1;
  localparam int RW = PW + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(LANES + 1);
  localparam logic signed [RW-1:0] MAXV = RW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;
  logic v1, v2, v3;
  logic signed [PW-1:0] p1 [LANES];
  logic signed [BIAS_W-1:0] b1;
  logic [SHIFT_W-1:0] sh1;
  logic re1, re2;
  logic signed [RW-1:0] q2 [LANES];
  logic signed [RW-1:0] rl [LANES];
  logic signed [RW-1:0] rnd;
  logic [LANES*OUT_W-1:0] y, d3;
  logic [LANES*OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rnext;
  logic [CW:0] occ;
  logic wr, pop;
  assign rnd = sh1 != '0 ? RW'(1) << (sh1 - 1'b1) : '0;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign rl[i] = (re2 && q2[i] < 0) ? '0 : q2[i];
    assign y[i*OUT_W +: OUT_W] = rl[i] > MAXV ? MAXV[OUT_W-1:0] : rl[i] < MINV ? MINV[OUT_W-1:0] : rl[i][OUT_W-1:0];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      p1[i] <= PW'($signed(partial_sum[i*ACC_W +: ACC_W])) * PW'($signed({1'b0, scale}));
      q2[i] <= ((RW'(p1[i]) + rnd) >>> sh1) + RW'(b1);
    end
    b1 <= bias;
    sh1 <= shift;
    re1 <= relu_en;
    re2 <= re1;
    d3 <= y;
    if (wr) mem[wptr] <= d3;
  end
  assign wr = v3;
  assign pop = out_ready && count != '0;
  assign rnext = rptr + AW'(pop);
  assign occ = {1'b0, count} + (CW+1)'(v1) + (CW+1)'(v2) + (CW+1)'(v3);
  assign in_ready = occ < (CW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign full = count == CW'(DEPTH);
  // out_data is a register so it can hold the last popped row while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1, v2, v3} <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      out_data <= '0;
    end else begin
      v1 <= in_valid && in_ready;
      v2 <= v1;
      v3 <= v2;
      wptr <= wptr + AW'(wr);
      rptr <= rnext;
      count <= count + CW'(wr) - CW'(pop);
      if (wr && count == CW'(pop)) out_data <= d3;
      else if (count > CW'(pop)) out_data <= mem[rnext];
    end
  end
`ifdef PPU_SAT_STATS_EN
  logic [NW-1:0] nsat, n3;
  logic [15:0] sat_q;
  always_comb begin
    nsat = '0;
    for (int i = 0; i < LANES; i++) nsat = nsat + NW'(rl[i] > MAXV || rl[i] < MINV);
  end
  always_ff @(posedge clk) n3 <= nsat;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= '0;
    else if (sat_clr) sat_q <= '0;
    else if (wr) sat_q <= (17'(sat_q) + 17'(n3)) > 17'h0FFFF ? 16'hFFFF : sat_q + 16'(n3);
  end
  assign sat_count = sat_q;
`else
  logic unused_sat_clr;
  assign unused_sat_clr = sat_clr;
  assign sat_count = '0;
`endif
endmodule

// File: tb/tb_ppu_requant_buffer.sv
// tb_ppu_requant_buffer: random + directed stimulus against an integer reference model and a row scoreboard.
module tb_ppu_requant_buffer;
  localparam int LANES = 16, ACC_W = 24, OUT_W = 8, DEPTH = 16;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, relu_en = 0, out_valid, out_ready = 0, full, sat_clr = 0;
  logic [LANES*ACC_W-1:0] partial_sum = '0;
  logic [7:0] scale = '0, bias = '0;
  logic [4:0] shift = '0;
  logic [LANES*OUT_W-1:0] out_data;
  logic [4:0] count;
  logic [15:0] sat_count;
  logic [127:0] exp_q [$];
  int total = 0, bad = 0, exp_sat = 0, n_in = 0, n_out = 0;

  ppu_requant_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .partial_sum(partial_sum),
    .scale(scale), .bias(bias), .shift(shift), .relu_en(relu_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count), .full(full),
    .sat_count(sat_count), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(output logic [127:0] row, output int nsat);
    longint a, r;
    nsat = 0;
    row = '0;
    for (int i = 0; i < LANES; i++) begin
      a = longint'($signed(partial_sum[i*ACC_W +: ACC_W]));
      r = a * longint'(scale);
      if (shift > 0) r = (r + (longint'(1) <<< (shift - 1))) >>> shift;
      r = r + longint'($signed(bias));
      if (relu_en && r < 0) r = 0;
      if (r > 127) begin r = 127; nsat++; end
      if (r < -128) begin r = -128; nsat++; end
      row[i*OUT_W +: OUT_W] = r[7:0];
    end
  endfunction

  function automatic int sat_ref();
`ifdef PPU_SAT_STATS_EN
    return exp_sat > 65535 ? 65535 : exp_sat;
`else
    return 0;
`endif
  endfunction

  task automatic cycle();
    logic [127:0] r;
    int n;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
      else chk("row", out_data, exp_q.pop_front());
    end
    if (in_valid && in_ready) begin
      model(r, n);
      exp_q.push_back(r);
      exp_sat += n;
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_row();
    logic [31:0] v;
    for (int i = 0; i < LANES; i++) begin
      v = $urandom;
      if ($urandom_range(0, 3) != 0) v = {{20{v[11]}}, v[11:0]};
      partial_sum[i*ACC_W +: ACC_W] = v[23:0];
    end
    scale = 8'($urandom);
    bias = 8'($urandom);
    shift = 5'($urandom_range(0, 20));
    relu_en = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_row(input logic [23:0] a, input logic [7:0] sc, input logic [7:0] bi, input logic [4:0] sh, input logic re);
    for (int i = 0; i < LANES; i++) partial_sum[i*ACC_W +: ACC_W] = a;
    scale = sc; bias = bi; shift = sh; relu_en = re;
  endtask

  task automatic one_row(input string tag, input logic [127:0] exp);
    out_ready = 0;
    in_valid = 1;
    cycle();
    in_valid = 0;
    cycle();
    cycle();
    chk({tag, "_lat2"}, out_valid, 0);
    cycle();
    chk({tag, "_lat3"}, out_valid, 1);
    chk(tag, out_data, exp);
    out_ready = 1;
    cycle();
    out_ready = 0;
    chk({tag, "_empty"}, out_valid, 0);
    chk({tag, "_hold"}, out_data, exp);
  endtask

  task automatic drain(input string tag);
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || count != 0); i++) cycle();
    chk({tag, "_drained"}, 128'(exp_q.size()), 0);
    chk({tag, "_count0"}, count, 0);
    out_ready = 0;
  endtask

  initial begin
    #3;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", sat_count, 0);
    chk("rst_full", full, 0);
    #20 rst = 0;
    @(posedge clk); #1;
    chk("rst_ready", in_ready, 1);

    fill_row(24'h800000, 8'd16, 8'd1, 5'd0, 1'b0);
    one_row("neg_sat", {16{8'h80}});
    chk("sat_after_neg", sat_count, 16'(sat_ref()));
    fill_row(24'h800000, 8'd16, 8'd1, 5'd0, 1'b1);
    one_row("relu", '0);
    chk("sat_after_relu", sat_count, 16'(sat_ref()));
    fill_row(24'd100, 8'd3, 8'd5, 5'd2, 1'b0);
    one_row("round_pos", {16{8'h50}});
    fill_row(-24'sd6, 8'd1, 8'd0, 5'd2, 1'b0);
    one_row("round_neg", {16{8'hFF}});

    n_in = 0; n_out = 0;
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 30; i++) begin rand_row(); cycle(); end
    in_valid = 0;
    chk("fill_accepted", n_in, 16);
    chk("fill_ready", in_ready, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    drain("fill");
    chk("fill_pops", n_out, 16);
    chk("fill_valid", out_valid, 0);
    chk("fill_notfull", full, 0);

    in_valid = 1;
    out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      rand_row();
      cycle();
      if (i >= 4) begin
        chk("stream_count", count, 1);
        chk("stream_ready", in_ready, 1);
      end
    end
    drain("stream");
    chk("sat_stream", sat_count, 16'(sat_ref()));

    sat_clr = 1;
    cycle();
    sat_clr = 0;
    exp_sat = 0;
    chk("sat_clr", sat_count, 16'(sat_ref()));

    for (int i = 0; i < 300; i++) begin
      rand_row();
      in_valid = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    drain("rand");
    chk("sat_rand", sat_count, 16'(sat_ref()));

    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 7; i++) begin rand_row(); cycle(); end
    in_valid = 0;
    cycle();
    chk("pre_rst_count", count, 5);
    #2 rst = 1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sat", sat_count, 0);
    exp_q.delete();
    exp_sat = 0;
    #3 rst = 0;
    @(posedge clk); #1;
    fill_row(24'd100, 8'd3, 8'd5, 5'd2, 1'b0);
    one_row("post_rst", {16{8'h50}});
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
